// File: rtl/vcpu_pkg.sv
// vcpu_pkg: shared types and constants for the vector-cpu run controller.
//   run_state_t : run controller FSM states
//   DefN, DefR  : default lane width and lanes per vector word
//   VW          : default vector word width (R*N)
package vcpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    COMW,
    DONE,
    TOUT
  } run_state_t;

  localparam int unsigned DefN = 8;
  localparam int unsigned DefR = 6;
  localparam int unsigned VW   = DefR * DefN;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: CW-bit RUN-cycle counter with synchronous clear and count enable.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : zero the count (wins over en)
//   en         : advance the count by one
//   count      : current count
//   terminal   : count has reached MAX_CYCLES-1
module run_cycle_counter #(
  parameter int unsigned CW         = 21,
  parameter int unsigned MAX_CYCLES = 2 ** 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CW'(MAX_CYCLES - 1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences a cpu program run and arbitrates the single data_mem port.
//   Host side  : host_go/host_abort/host_ack pulses, host_we/host_addr/host_wd memory request
//   Cpu side   : cpu_end (EndFlag), cpu_com (COMFlag), cpu_we/cpu_addr/cpu_wd memory request
//   Cpu control: cpu_reset, cpu_start (cpu holds PC/state while cpu_start=0)
//   Memory     : mem_we/mem_addr/mem_wd, combinational mux of the owning side
//   Status     : busy, done, timeout, com_req, cycle_count (RUN cycles of current/last run)
module cpu_run_ctrl
  import vcpu_pkg::*;
#(
  parameter int unsigned I          = 32,
  parameter int unsigned N          = DefN,
  parameter int unsigned R          = DefR,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned MAX_CYCLES = 2 ** 20,
  parameter int unsigned CW         = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_go,
  input  logic          host_abort,
  input  logic          host_ack,
  input  logic          host_we,
  input  logic [I-1:0]  host_addr,
  input  logic [R*N-1:0] host_wd,
  input  logic          cpu_end,
  input  logic          cpu_com,
  input  logic          cpu_we,
  input  logic [I-1:0]  cpu_addr,
  input  logic [R*N-1:0] cpu_wd,
  output logic          cpu_reset,
  output logic          cpu_start,
  output logic          mem_we,
  output logic [I-1:0]  mem_addr,
  output logic [R*N-1:0] mem_wd,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          com_req,
  output logic [CW-1:0] cycle_count
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_state_t    state_q, state_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic          cnt_clr, cnt_en, cnt_term;

  logic cpu_reset_d, cpu_start_d, busy_d, done_d, timeout_d, com_req_d;

  run_cycle_counter #(
    .CW        (CW),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_run_cycle_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .count   (cycle_count),
    .terminal(cnt_term)
  );

  // Aborted RUN cycles are not counted.
  assign cnt_en = (state_q == RUN) && !host_abort;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_clr   = 1'b0;
    if (host_abort) begin
      // Abort outranks every other input, including a go in IDLE.
      if (state_q != IDLE) begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE, TOUT: begin
          if (host_go) begin
            state_d   = RST;
            rst_cnt_d = '0;
            cnt_clr   = 1'b1;
          end
        end
        RST: begin
          if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            rst_cnt_d = rst_cnt_q + RstW'(1);
          end
        end
        RUN: begin
          if (cpu_end) begin
            state_d = DONE;
          end else if (cnt_term) begin
            state_d = TOUT;
          end else if (cpu_com) begin
            state_d = COMW;
          end
        end
        COMW: begin
          if (host_ack) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they are glitch-free registers.
  always_comb begin
    cpu_reset_d = (state_d == IDLE) || (state_d == RST) || (state_d == TOUT);
    cpu_start_d = (state_d == RUN);
    busy_d      = (state_d == RST) || (state_d == RUN) || (state_d == COMW);
    done_d      = (state_d == DONE);
    timeout_d   = (state_d == TOUT);
    com_req_d   = (state_d == COMW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      cpu_reset <= 1'b1;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      com_req   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cpu_reset <= cpu_reset_d;
      cpu_start <= cpu_start_d;
      busy      <= busy_d;
      done      <= done_d;
      timeout   <= timeout_d;
      com_req   <= com_req_d;
    end
  end

  // Port ownership: cpu while running, host otherwise. Non-owner requests are dropped.
  always_comb begin
    mem_we   = host_we;
    mem_addr = host_addr;
    mem_wd   = host_wd;
    unique case (state_q)
      RUN: begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
      end
      RST: begin
        // Cpu in reset may drive garbage; block writes outright.
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

  localparam int unsigned I         = 32;
  localparam int unsigned VW        = 48;
  localparam int unsigned RstCycles = 4;
  localparam int unsigned MaxA      = 2 ** 20;
  localparam int unsigned CwA       = 21;
  localparam int unsigned MaxB      = 16;
  localparam int unsigned CwB       = 5;

  logic clk = 1'b0;
  logic reset;
  logic host_go, host_abort, host_ack, host_we;
  logic [I-1:0]  host_addr, cpu_addr;
  logic [VW-1:0] host_wd, cpu_wd;
  logic cpu_end, cpu_com, cpu_we;

  logic a_cpu_reset, a_cpu_start, a_mem_we, a_busy, a_done, a_timeout, a_com_req;
  logic [I-1:0]   a_mem_addr;
  logic [VW-1:0]  a_mem_wd;
  logic [CwA-1:0] a_cycle_count;
  logic b_cpu_reset, b_cpu_start, b_mem_we, b_busy, b_done, b_timeout, b_com_req;
  logic [I-1:0]   b_mem_addr;
  logic [VW-1:0]  b_mem_wd;
  logic [CwB-1:0] b_cycle_count;

  int n_err = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .I(I), .N(8), .R(6), .RST_CYCLES(RstCycles), .MAX_CYCLES(MaxA), .CW(CwA)
  ) dut_a (
    .clk(clk), .reset(reset), .host_go(host_go), .host_abort(host_abort),
    .host_ack(host_ack), .host_we(host_we), .host_addr(host_addr), .host_wd(host_wd),
    .cpu_end(cpu_end), .cpu_com(cpu_com), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_reset(a_cpu_reset), .cpu_start(a_cpu_start),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .busy(a_busy),
    .done(a_done), .timeout(a_timeout), .com_req(a_com_req), .cycle_count(a_cycle_count)
  );

  cpu_run_ctrl #(
    .I(I), .N(8), .R(6), .RST_CYCLES(RstCycles), .MAX_CYCLES(MaxB), .CW(CwB)
  ) dut_b (
    .clk(clk), .reset(reset), .host_go(host_go), .host_abort(host_abort),
    .host_ack(host_ack), .host_we(host_we), .host_addr(host_addr), .host_wd(host_wd),
    .cpu_end(cpu_end), .cpu_com(cpu_com), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_reset(b_cpu_reset), .cpu_start(b_cpu_start),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .busy(b_busy),
    .done(b_done), .timeout(b_timeout), .com_req(b_com_req), .cycle_count(b_cycle_count)
  );

  // Run model: a run is active from go until it ends; the first RstCycles cycles hold
  // the cpu in reset, then the cpu runs except while waiting for host service.
  bit          m_run[2]      = '{0, 0};
  int          m_rst_left[2] = '{0, 0};
  bit          m_wait[2]     = '{0, 0};
  bit          m_done[2]     = '{0, 0};
  bit          m_tout[2]     = '{0, 0};
  int unsigned m_cnt[2]      = '{0, 0};
  int unsigned m_max[2]      = '{MaxA, MaxB};

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_run[k] <= 0; m_rst_left[k] <= 0; m_wait[k] <= 0;
        m_done[k] <= 0; m_tout[k] <= 0; m_cnt[k] <= 0;
      end else if (host_abort) begin
        if (m_run[k] || m_done[k] || m_tout[k]) begin
          m_run[k] <= 0; m_rst_left[k] <= 0; m_wait[k] <= 0;
          m_done[k] <= 0; m_tout[k] <= 0;
        end
      end else if (!m_run[k]) begin
        if (host_go) begin
          m_run[k] <= 1; m_rst_left[k] <= RstCycles; m_cnt[k] <= 0;
          m_done[k] <= 0; m_tout[k] <= 0;
        end
      end else if (m_rst_left[k] > 0) begin
        m_rst_left[k] <= m_rst_left[k] - 1;
      end else if (m_wait[k]) begin
        if (host_ack) m_wait[k] <= 0;
      end else begin
        m_cnt[k] <= m_cnt[k] + 1;
        if (cpu_end) begin
          m_run[k] <= 0; m_done[k] <= 1;
        end else if (m_cnt[k] + 1 == m_max[k]) begin
          m_run[k] <= 0; m_tout[k] <= 1;
        end else if (cpu_com) begin
          m_wait[k] <= 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input string p, input logic cr, input logic cs,
                         input logic mwe, input logic [I-1:0] maddr, input logic [VW-1:0] mwd,
                         input logic bsy, input logic dn, input logic to, input logic cq,
                         input logic [31:0] cnt);
    bit in_rst, cpu_runs;
    in_rst   = m_run[k] && (m_rst_left[k] > 0);
    cpu_runs = m_run[k] && (m_rst_left[k] == 0) && !m_wait[k];
    chk({p, ".cpu_reset"}, cr, in_rst || (!m_run[k] && !m_done[k]));
    chk({p, ".cpu_start"}, cs, cpu_runs);
    chk({p, ".busy"}, bsy, m_run[k]);
    chk({p, ".done"}, dn, m_done[k]);
    chk({p, ".timeout"}, to, m_tout[k]);
    chk({p, ".com_req"}, cq, m_wait[k]);
    chk({p, ".cycle_count"}, cnt, m_cnt[k]);
    if (in_rst) begin
      chk({p, ".mem_we"}, mwe, 1'b0);
      chk({p, ".mem_addr"}, maddr, cpu_addr);
    end else if (cpu_runs) begin
      chk({p, ".mem_we"}, mwe, cpu_we);
      chk({p, ".mem_addr"}, maddr, cpu_addr);
      chk({p, ".mem_wd"}, mwd, cpu_wd);
    end else begin
      chk({p, ".mem_we"}, mwe, host_we);
      chk({p, ".mem_addr"}, maddr, host_addr);
      chk({p, ".mem_wd"}, mwd, host_wd);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      cmp_dut(0, "a", a_cpu_reset, a_cpu_start, a_mem_we, a_mem_addr, a_mem_wd, a_busy,
              a_done, a_timeout, a_com_req, 32'(a_cycle_count));
      cmp_dut(1, "b", b_cpu_reset, b_cpu_start, b_mem_we, b_mem_addr, b_mem_wd, b_busy,
              b_done, b_timeout, b_com_req, 32'(b_cycle_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_and_release();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    host_go = 0; host_abort = 0; host_ack = 0; host_we = 0;
    host_addr = '0; host_wd = '0;
    cpu_end = 0; cpu_com = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state and a host write passing straight through
    @(negedge clk);
    chk("rst.a_cpu_reset", a_cpu_reset, 1'b1);
    chk("rst.a_busy", a_busy, 1'b0);
    chk("rst.a_cycle_count", 64'(a_cycle_count), 0);
    chk("rst.b_cycle_count", 64'(b_cycle_count), 0);
    tick();
    host_we = 1'b1; host_addr = 32'h10; host_wd = 48'h010203040506;
    cpu_addr = 32'h44; cpu_wd = 48'hAAAA_BBBB_CCCC;
    @(negedge clk);
    chk("host_wr.mem_we", a_mem_we, 1'b1);
    chk("host_wr.mem_addr", a_mem_addr, 32'h10);
    chk("host_wr.mem_wd", a_mem_wd, 48'h010203040506);
    tick();
    host_we = 1'b0;

    // Full run ending on EndFlag at RUN cycle 20; the 16-cycle instance times out
    go_and_release();
    @(negedge clk);
    chk("rst_ph.a_cpu_reset", a_cpu_reset, 1'b1);
    chk("rst_ph.a_busy", a_busy, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("run1.a_cpu_start", a_cpu_start, 1'b1);
    chk("run1.a_cpu_reset", a_cpu_reset, 1'b0);
    repeat (19) tick();
    cpu_end = 1'b1;
    tick();
    cpu_end = 1'b0;
    @(negedge clk);
    chk("end20.a_done", a_done, 1'b1);
    chk("end20.a_busy", a_busy, 1'b0);
    chk("end20.a_cycle_count", 64'(a_cycle_count), 20);
    chk("tout.b_timeout", b_timeout, 1'b1);
    chk("tout.b_cpu_reset", b_cpu_reset, 1'b1);
    chk("tout.b_cycle_count", 64'(b_cycle_count), 16);

    // COMFlag service, resume, end at RUN cycle 9
    go_and_release();
    @(negedge clk);
    chk("go.b_timeout_clr", b_timeout, 1'b0);
    chk("go.a_done_clr", a_done, 1'b0);
    repeat (8) tick();
    cpu_com = 1'b1;
    tick();
    cpu_com = 1'b0;
    host_addr = 32'h20;
    @(negedge clk);
    chk("comw.a_com_req", a_com_req, 1'b1);
    chk("comw.a_cpu_start", a_cpu_start, 1'b0);
    chk("comw.a_mem_addr", a_mem_addr, 32'h20);
    chk("comw.a_cycle_count", 64'(a_cycle_count), 5);
    repeat (2) tick();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    repeat (3) tick();
    cpu_end = 1'b1;
    tick();
    cpu_end = 1'b0;
    @(negedge clk);
    chk("end9.a_cycle_count", 64'(a_cycle_count), 9);
    chk("end9.b_cycle_count", 64'(b_cycle_count), 9);
    chk("end9.a_done", a_done, 1'b1);

    // EndFlag and COMFlag together: EndFlag wins
    go_and_release();
    repeat (4) tick();
    cpu_end = 1'b1; cpu_com = 1'b1;
    tick();
    cpu_end = 1'b0; cpu_com = 1'b0;
    @(negedge clk);
    chk("both.a_done", a_done, 1'b1);
    chk("both.a_com_req", a_com_req, 1'b0);
    chk("both.a_cycle_count", 64'(a_cycle_count), 1);

    // Abort during COMW; cpu writes in RST and IDLE never reach memory
    host_go = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30;
    tick();
    host_go = 1'b0;
    @(negedge clk);
    chk("rst_we.a_mem_we", a_mem_we, 1'b0);
    repeat (4) tick();
    cpu_we = 1'b0;
    tick();
    cpu_com = 1'b1;
    tick();
    cpu_com = 1'b0;
    @(negedge clk);
    chk("comw2.a_com_req", a_com_req, 1'b1);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    cpu_we = 1'b1; host_we = 1'b0;
    @(negedge clk);
    chk("abort.a_com_req", a_com_req, 1'b0);
    chk("abort.a_cpu_reset", a_cpu_reset, 1'b1);
    chk("abort.a_busy", a_busy, 1'b0);
    chk("idle_we.a_mem_we", a_mem_we, 1'b0);
    repeat (3) tick();
    cpu_we = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
